// File: rtl/mem_req_arbiter_if.sv
// Bundle of the channel-side and memory-side signals of the shared memory port arbiter.
// The arbiter takes the slave view; requesters and the memory controller take the master view.
interface mem_req_arbiter_if #(
    parameter int NCH = 3,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH-1:0]    ch_w;
    logic [NCH-1:0]    ch_hw;
    logic [NCH*AW-1:0] ch_adr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_done;
    logic [NCH-1:0]    ch_err;
    logic [DW-1:0]     ch_rdata;
    logic              busy;
    logic              m_read_req;
    logic              m_write_req;
    logic              m_w;
    logic              m_hw;
    logic [AW-1:0]     m_adr;
    logic [DW-1:0]     m_wdata;
    logic              m_read_valid;
    logic [DW-1:0]     m_read_data;
    logic              m_write_finish;

    modport slave (
        input  ch_req, ch_we, ch_w, ch_hw, ch_adr, ch_wdata,
        input  m_read_valid, m_read_data, m_write_finish,
        output ch_done, ch_err, ch_rdata, busy,
        output m_read_req, m_write_req, m_w, m_hw, m_adr, m_wdata
    );

    modport master (
        output ch_req, ch_we, ch_w, ch_hw, ch_adr, ch_wdata,
        output m_read_valid, m_read_data, m_write_finish,
        input  ch_done, ch_err, ch_rdata, busy,
        input  m_read_req, m_write_req, m_w, m_hw, m_adr, m_wdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin N-channel arbiter for the single shared memory port, one transaction in flight.
// Optional busy-timeout with error pulse is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
    parameter int NCH    = 3,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_req_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  gnt;
    logic           we_q;
    logic           read_req;
    logic           write_req;
    logic           size_w;
    logic           size_hw;
    logic [AW-1:0]  adr_q;
    logic [DW-1:0]  wdata_q;
    logic [NCH-1:0] done_q;
    logic [DW-1:0]  rdata_q;

    logic [IW-1:0]  pick;
    logic           sel_we;
    logic           sel_w;
    logic           sel_hw;
    logic [AW-1:0]  sel_adr;
    logic [DW-1:0]  sel_wdata;
    logic [NCH-1:0] gnt_oh;
    logic           complete;

    // First requester after the last granted index, wrapping modulo NCH.
    function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] req, input logic [IW-1:0] last);
        logic [IW-1:0] sel;
        logic [IW-1:0] idx;
        sel = last;
        for (int off = NCH; off >= 1; off--) begin
            idx = IW'((int'(last) + off) % NCH);
            if (req[idx]) sel = idx;
        end
        return sel;
    endfunction

    always_comb begin
        pick      = rr_pick(bus.ch_req, rr);
        sel_we    = 1'b0;
        sel_w     = 1'b0;
        sel_hw    = 1'b0;
        sel_adr   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pick == IW'(i)) begin
                sel_we    = bus.ch_we[i];
                sel_w     = bus.ch_w[i];
                sel_hw    = bus.ch_hw[i];
                sel_adr   = bus.ch_adr[i*AW +: AW];
                sel_wdata = bus.ch_wdata[i*DW +: DW];
            end
        end
    end

    assign gnt_oh   = NCH'(1) << gnt;
    // Only the completion matching the latched direction counts; the other one is ignored.
    assign complete = we_q ? bus.m_write_finish : bus.m_read_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);

    logic [TW-1:0]  to_cnt;
    logic           to_hit;
    logic [NCH-1:0] err_q;

    // Fires at the end of the TO_CYC-th busy cycle.
    assign to_hit     = (to_cnt == TW'(TO_CYC - 1));
    assign bus.ch_err = err_q;
`else
    assign bus.ch_err = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= IW'(NCH - 1);
            gnt       <= '0;
            we_q      <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            size_w    <= 1'b0;
            size_hw   <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.ch_req) begin
                        gnt       <= pick;
                        rr        <= pick;
                        we_q      <= sel_we;
                        read_req  <= ~sel_we;
                        write_req <= sel_we;
                        size_w    <= sel_w;
                        size_hw   <= sel_hw;
                        adr_q     <= sel_adr;
                        wdata_q   <= sel_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                        state     <= BUSY;
                    end
                end
                BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt <= to_cnt + 1'b1;
`endif
                    if (complete) begin
                        if (!we_q) rdata_q <= bus.m_read_data;
                        read_req  <= 1'b0;
                        write_req <= 1'b0;
                        done_q    <= gnt_oh;
                        state     <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        rdata_q   <= '0;
                        read_req  <= 1'b0;
                        write_req <= 1'b0;
                        done_q    <= gnt_oh;
                        err_q     <= gnt_oh;
                        state     <= DONE;
                    end
`endif
                end
                DONE: begin
                    // Gap cycle: the finished requester drops ch_req here, so no grant yet.
                    done_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err_q  <= '0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ch_done     = done_q;
    assign bus.ch_rdata    = rdata_q;
    assign bus.busy        = (state != IDLE);
    assign bus.m_read_req  = read_req;
    assign bus.m_write_req = write_req;
    assign bus.m_w         = size_w;
    assign bus.m_hw        = size_hw;
    assign bus.m_adr       = adr_q;
    assign bus.m_wdata     = wdata_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: read, round-robin order, write, reset abort, address hold,
// and (with MEM_ARB_TIMEOUT_EN) the timeout path with TO_CYC=4.
module tb_mem_req_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_req_arbiter_if #(.NCH(3), .AW(32), .DW(32)) bus ();

    mem_req_arbiter #(.NCH(3), .AW(32), .DW(32), .TO_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] order [4];
        logic [2:0] exp_oh;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ch_req = '0; bus.ch_we = '0; bus.ch_w = '0; bus.ch_hw = '0;
        bus.ch_adr = '0; bus.ch_wdata = '0;
        bus.m_read_valid = 1'b0; bus.m_read_data = '0; bus.m_write_finish = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_done", 64'(bus.ch_done), 64'h0);
        chk("rst_err", 64'(bus.ch_err), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        chk("rst_rreq", 64'(bus.m_read_req), 64'h0);
        chk("rst_wreq", 64'(bus.m_write_req), 64'h0);
        chk("rst_adr", 64'(bus.m_adr), 64'h0);
        chk("rst_rdata", 64'(bus.ch_rdata), 64'h0);

        // Test 1: single read on ch0, completion in third busy cycle
        rst_n = 1'b1;
        bus.ch_req = 3'b001; bus.ch_w = 3'b001;
        bus.ch_adr = {32'h0, 32'h0, 32'h100};
        tick();
        chk("t1_busy", 64'(bus.busy), 64'h1);
        chk("t1_rreq", 64'(bus.m_read_req), 64'h1);
        chk("t1_wreq", 64'(bus.m_write_req), 64'h0);
        chk("t1_adr", 64'(bus.m_adr), 64'h100);
        chk("t1_w", 64'(bus.m_w), 64'h1);
        tick();
        chk("t1_nodone_c2", 64'(bus.ch_done), 64'h0);
        tick();
        bus.m_read_valid = 1'b1; bus.m_read_data = 32'hCAFE0001;
        tick();
        chk("t1_done", 64'(bus.ch_done), 64'h1);
        chk("t1_rdata", 64'(bus.ch_rdata), 64'hCAFE0001);
        chk("t1_rreq_drop", 64'(bus.m_read_req), 64'h0);
        chk("t1_busy_done", 64'(bus.busy), 64'h1);
        bus.m_read_valid = 1'b0; bus.ch_req = 3'b000;
        tick();
        chk("t1_done_once", 64'(bus.ch_done), 64'h0);
        chk("t1_busy_fall", 64'(bus.busy), 64'h0);
        chk("t1_rdata_hold", 64'(bus.ch_rdata), 64'hCAFE0001);

        // Test 2: all three channels requesting, one-cycle memory -> 0,1,2,0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.ch_adr = {32'h30, 32'h20, 32'h10};
        bus.ch_req = 3'b111;
        order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            exp_oh = 3'b001 << order[i];
            tick();
            chk("t2_adr", 64'(bus.m_adr), 64'h10 * (64'(order[i]) + 1));
            chk("t2_rreq", 64'(bus.m_read_req), 64'h1);
            bus.m_read_valid = 1'b1; bus.m_read_data = 32'hA0 + 32'(i);
            tick();
            chk("t2_done", 64'(bus.ch_done), 64'(exp_oh));
            chk("t2_rdata", 64'(bus.ch_rdata), 64'hA0 + 64'(i));
            bus.m_read_valid = 1'b0;
            if (i == 3) bus.ch_req = 3'b000;
            tick();
            chk("t2_idle", 64'(bus.busy), 64'h0);
        end

        // Test 3 + 6: write on ch2, wrong-type completion ignored, req/adr changes while busy ignored
        bus.ch_req = 3'b100; bus.ch_we = 3'b100; bus.ch_w = 3'b000; bus.ch_hw = 3'b100;
        bus.ch_adr = {32'h2000, 32'h20, 32'h10};
        bus.ch_wdata = {32'h12345678, 32'h0, 32'h0};
        tick();
        chk("t3_wreq", 64'(bus.m_write_req), 64'h1);
        chk("t3_rreq", 64'(bus.m_read_req), 64'h0);
        chk("t3_hw", 64'(bus.m_hw), 64'h1);
        chk("t3_w", 64'(bus.m_w), 64'h0);
        chk("t3_adr", 64'(bus.m_adr), 64'h2000);
        chk("t3_wdata", 64'(bus.m_wdata), 64'h12345678);
        bus.m_read_valid = 1'b1; bus.m_read_data = 32'hDEAD;
        tick();
        chk("t3_rv_ignored", 64'(bus.ch_done), 64'h0);
        chk("t3_still_wreq", 64'(bus.m_write_req), 64'h1);
        bus.m_read_valid = 1'b0;
        bus.ch_adr = {32'h3000, 32'h20, 32'h10};
        bus.ch_wdata = {32'h87654321, 32'h0, 32'h0};
        bus.ch_req = 3'b000;
        tick();
        chk("t6_adr_hold", 64'(bus.m_adr), 64'h2000);
        chk("t6_wdata_hold", 64'(bus.m_wdata), 64'h12345678);
        chk("t3_busy_dropreq", 64'(bus.busy), 64'h1);
        bus.m_write_finish = 1'b1;
        tick();
        chk("t3_done", 64'(bus.ch_done), 64'h4);
        chk("t3_wreq_drop", 64'(bus.m_write_req), 64'h0);
        chk("t3_rdata_hold", 64'(bus.ch_rdata), 64'hA3);
        bus.m_write_finish = 1'b0;
        bus.ch_we = 3'b000; bus.ch_hw = 3'b000;
        tick();
        chk("t3_idle", 64'(bus.busy), 64'h0);

        // Test 4: reset during busy, late completion ignored, ch0 wins first after reset
        bus.ch_adr = {32'h30, 32'h20, 32'h10};
        bus.ch_req = 3'b010;
        tick();
        chk("t4_grant1", 64'(bus.m_adr), 64'h20);
        rst_n = 1'b0;
        tick();
        chk("t4_rst_busy", 64'(bus.busy), 64'h0);
        chk("t4_rst_rreq", 64'(bus.m_read_req), 64'h0);
        chk("t4_rst_adr", 64'(bus.m_adr), 64'h0);
        rst_n = 1'b1; bus.ch_req = 3'b000;
        bus.m_read_valid = 1'b1; bus.m_read_data = 32'hBAD;
        tick();
        chk("t4_late_rv", 64'(bus.ch_done), 64'h0);
        tick();
        chk("t4_late_rv2", 64'(bus.ch_done), 64'h0);
        chk("t4_late_rdata", 64'(bus.ch_rdata), 64'h0);
        bus.m_read_valid = 1'b0;
        bus.ch_req = 3'b011;
        tick();
        chk("t4_first_ch0", 64'(bus.m_adr), 64'h10);
        bus.ch_req = 3'b010;
        bus.m_read_valid = 1'b1; bus.m_read_data = 32'h55;
        tick();
        chk("t4_done", 64'(bus.ch_done), 64'h1);
        chk("t4_rdata", 64'(bus.ch_rdata), 64'h55);
        bus.m_read_valid = 1'b0; bus.ch_req = 3'b000;
        tick();
        chk("t4_idle", 64'(bus.busy), 64'h0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Test 5: timeout after four busy cycles, then completion exactly in cycle four
        bus.ch_req = 3'b001; bus.ch_adr = {32'h30, 32'h20, 32'h100};
        tick();
        chk("t5_rreq", 64'(bus.m_read_req), 64'h1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("t5_wait", 64'(bus.ch_done), 64'h0);
        end
        tick();
        chk("t5_to_done", 64'(bus.ch_done), 64'h1);
        chk("t5_to_err", 64'(bus.ch_err), 64'h1);
        chk("t5_to_rdata", 64'(bus.ch_rdata), 64'h0);
        chk("t5_to_rreq", 64'(bus.m_read_req), 64'h0);
        bus.ch_req = 3'b000;
        tick();
        chk("t5_err_pulse", 64'(bus.ch_err), 64'h0);
        bus.ch_req = 3'b001;
        tick();
        tick();
        tick();
        tick();
        bus.m_read_valid = 1'b1; bus.m_read_data = 32'h77;
        tick();
        chk("t5_edge_done", 64'(bus.ch_done), 64'h1);
        chk("t5_edge_err", 64'(bus.ch_err), 64'h0);
        chk("t5_edge_rdata", 64'(bus.ch_rdata), 64'h77);
        bus.m_read_valid = 1'b0; bus.ch_req = 3'b000;
        tick();
`else
        chk("err_tied", 64'(bus.ch_err), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
